// File: rtl/alu_issue_stage.sv
// One-entry operand-select/pipeline stage in front of the 32-bit ALU.
// Define FORWARD_EN to enable EX/MEM and MEM/WB forwarding; otherwise hazards stall in_ready.
module alu_issue_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [REGW-1:0] in_rs1_addr,
    input  logic [REGW-1:0] in_rs2_addr,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_use_imm,
    input  logic [3:0]      in_aluc,
    input  logic [REGW-1:0] in_rd_addr,
    input  logic            in_rd_we,
    input  logic            flush,
    input  logic [REGW-1:0] ex_rd_addr,
    input  logic            ex_rd_we,
    input  logic [XLEN-1:0] ex_result,
    input  logic [REGW-1:0] wb_rd_addr,
    input  logic            wb_rd_we,
    input  logic [XLEN-1:0] wb_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rs1,
    output logic [XLEN-1:0] out_rs2,
    output logic [XLEN-1:0] out_store_data,
    output logic [3:0]      out_aluc,
    output logic            out_illegal,
    output logic [REGW-1:0] out_rd_addr,
    output logic            out_rd_we
);

    logic [XLEN-1:0] rs1_sel;
    logic [XLEN-1:0] rs2_sel;
    logic            hazard;
    logic            accept;
    logic            illegal;

    function automatic logic bus_match(input logic [REGW-1:0] addr,
                                       input logic [REGW-1:0] bus_addr,
                                       input logic            bus_we);
        return (addr != '0) && bus_we && (bus_addr == addr);
    endfunction

`ifdef FORWARD_EN
    // EX/MEM is younger than MEM/WB, so it wins when both match.
    function automatic logic [XLEN-1:0] fwd_sel(input logic [REGW-1:0] addr,
                                                input logic [XLEN-1:0] rf_data);
        if (addr == '0)
            return '0;
        else if (bus_match(addr, ex_rd_addr, ex_rd_we))
            return ex_result;
        else if (bus_match(addr, wb_rd_addr, wb_rd_we))
            return wb_result;
        else
            return rf_data;
    endfunction

    assign rs1_sel = fwd_sel(in_rs1_addr, in_rs1_data);
    assign rs2_sel = fwd_sel(in_rs2_addr, in_rs2_data);
    assign hazard  = 1'b0;
`else
    assign rs1_sel = (in_rs1_addr == '0) ? '0 : in_rs1_data;
    assign rs2_sel = (in_rs2_addr == '0) ? '0 : in_rs2_data;
    // rs2 always counts as a source because store data consumes it even with an immediate.
    assign hazard  = in_valid &&
                     (bus_match(in_rs1_addr, ex_rd_addr, ex_rd_we) ||
                      bus_match(in_rs1_addr, wb_rd_addr, wb_rd_we) ||
                      bus_match(in_rs2_addr, ex_rd_addr, ex_rd_we) ||
                      bus_match(in_rs2_addr, wb_rd_addr, wb_rd_we));
`endif

    assign in_ready = (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready && !flush;
    assign illegal  = (in_aluc > 4'd8);

    // Stage boundary: decoded instruction -> registered ALU operands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_rs1        <= '0;
            out_rs2        <= '0;
            out_store_data <= '0;
            out_aluc       <= '0;
            out_illegal    <= 1'b0;
            out_rd_addr    <= '0;
            out_rd_we      <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_rd_we <= 1'b0;
        end else if (accept) begin
            out_valid      <= 1'b1;
            out_rs1        <= rs1_sel;
            out_rs2        <= in_use_imm ? in_imm : rs2_sel;
            out_store_data <= rs2_sel;
            out_aluc       <= illegal ? 4'd0 : in_aluc;
            out_illegal    <= illegal;
            out_rd_addr    <= in_rd_addr;
            out_rd_we      <= in_rd_we && !illegal && (in_rd_addr != '0);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
